// File: rtl/run_monitor.sv
// Run controller and trace monitor for a MIPS_R2000 core.
// It sequences the core reset and gates the core clock-enable. It counts
// RUN cycles and retired instructions. A run ends on halt (PC self-loop),
// on timeout or on abort. A ring buffer holds the last TRACE_DEPTH PC/IR pairs.
// Handshake: Start and Abort are single-cycle level requests sampled on the
// rising edge. Start is honoured in IDLE/DONE and Abort in RESET/RUN. Start
// wins over Abort when both are high in IDLE/DONE.
module run_monitor #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 2048,
  parameter int RST_CYCLES  = 2,
  parameter int STALL_LIMIT = 16,
  parameter int TRACE_DEPTH = 8,
  localparam int IDX_W      = $clog2(TRACE_DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] PC,
  input  logic [DATA_W-1:0] Instr,
  output logic              CoreRst,
  output logic              CoreEn,
  output logic              Running,
  output logic              Done,
  output logic [1:0]        DoneCause,
  output logic [CNT_W-1:0]  CycleCnt,
  output logic [CNT_W-1:0]  RetireCnt,
  input  logic [IDX_W-1:0]  TraceIdx,
  output logic [ADDR_W-1:0] TracePC,
  output logic [DATA_W-1:0] TraceIR,
  output logic              TraceValid
);

  localparam int TW = IDX_W + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_CYCLES);
  localparam logic [SW-1:0]    STALL_V = SW'(STALL_LIMIT);
  localparam logic [RW-1:0]    RLOAD_V = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]    DEPTH_V = TW'(TRACE_DEPTH);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_HALT    = 2'b10;
  localparam logic [1:0] CAUSE_ABORT   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    retire_q, retire_d;
  logic [SW-1:0]       stall_q, stall_d;
  logic                first_q, first_d;
  logic [ADDR_W-1:0]   prev_q, prev_d;
  logic [IDX_W-1:0]    wptr_q, wptr_d;
  logic [TW-1:0]       tcount_q, tcount_d;
  logic [1:0]          cause_q, cause_d;
  logic                core_rst_q, core_rst_d;
  logic                core_en_q, core_en_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                trace_we;
  logic                launch;
  logic [ADDR_W-1:0]   trace_pc_q [TRACE_DEPTH];
  logic [DATA_W-1:0]   trace_ir_q [TRACE_DEPTH];
  logic [IDX_W-1:0]    rd_ptr;

  // Next-state, counter and trace-write decode; outputs follow the next state
  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    cycle_d    = cycle_q;
    retire_d   = retire_q;
    stall_d    = stall_q;
    first_d    = first_q;
    prev_d     = prev_q;
    wptr_d     = wptr_q;
    tcount_d   = tcount_q;
    cause_d    = cause_q;
    trace_we   = 1'b0;
    launch     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) launch = 1'b1;
      end
      S_RESET: begin
        if (Abort) begin
          state_d = S_DONE;
          cause_d = CAUSE_ABORT;
        end else if (rcnt_q == '0) begin
          state_d = S_RUN;
          first_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      S_RUN: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (first_q) begin
          // First RUN cycle only seeds the trace and the PC reference
          first_d  = 1'b0;
          prev_d   = PC;
          trace_we = 1'b1;
        end else if (PC != prev_q) begin
          retire_d = retire_q + CNT_W'(1);
          stall_d  = '0;
          prev_d   = PC;
          trace_we = 1'b1;
        end else if (stall_q < STALL_V) begin
          stall_d = stall_q + SW'(1);
        end
        if (Abort) begin
          state_d = S_DONE;
          cause_d = CAUSE_ABORT;
        end else if (stall_d == STALL_V) begin
          state_d = S_DONE;
          cause_d = CAUSE_HALT;
        end else if (cycle_d == MAX_V) begin
          state_d = S_DONE;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d  = S_RESET;
      rcnt_d   = RLOAD_V;
      cycle_d  = '0;
      retire_d = '0;
      stall_d  = '0;
      tcount_d = '0;
      wptr_d   = '0;
      cause_d  = CAUSE_NONE;
      first_d  = 1'b1;
    end

    if (trace_we) begin
      wptr_d = wptr_q + IDX_W'(1);
      if (tcount_q != DEPTH_V) tcount_d = tcount_q + TW'(1);
    end

    core_rst_d = (state_d == S_IDLE) || (state_d == S_RESET);
    core_en_d  = (state_d == S_RUN);
    running_d  = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      rcnt_q     <= '0;
      cycle_q    <= '0;
      retire_q   <= '0;
      stall_q    <= '0;
      first_q    <= 1'b0;
      prev_q     <= '0;
      wptr_q     <= '0;
      tcount_q   <= '0;
      cause_q    <= CAUSE_NONE;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      cycle_q    <= cycle_d;
      retire_q   <= retire_d;
      stall_q    <= stall_d;
      first_q    <= first_d;
      prev_q     <= prev_d;
      wptr_q     <= wptr_d;
      tcount_q   <= tcount_d;
      cause_q    <= cause_d;
      core_rst_q <= core_rst_d;
      core_en_q  <= core_en_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  // Trace ring storage, written at the current write pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        trace_pc_q[i] <= '0;
        trace_ir_q[i] <= '0;
      end
    end else if (trace_we) begin
      trace_pc_q[wptr_q] <= PC;
      trace_ir_q[wptr_q] <= Instr;
    end
  end

  // Newest-first read: index 0 is the entry just behind the write pointer
  always_comb begin
    rd_ptr     = wptr_q - IDX_W'(1) - TraceIdx;
    TracePC    = trace_pc_q[rd_ptr];
    TraceIR    = trace_ir_q[rd_ptr];
    TraceValid = ({1'b0, TraceIdx} < tcount_q);
  end

  assign CoreRst   = core_rst_q;
  assign CoreEn    = core_en_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign DoneCause = cause_q;
  assign CycleCnt  = cycle_q;
  assign RetireCnt = retire_q;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: a behavioural run model pushes the
// expected results of each run to a queue, which is popped once Done rises.
module tb_run_monitor;

  localparam int W      = 32;
  localparam int DEPTH  = 8;
  localparam int MAXC   = 2048;
  localparam int RSTC   = 2;
  localparam int STALLL = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         Start = 1'b0;
  logic         Abort = 1'b0;
  logic [W-1:0] PC = '0;
  logic [W-1:0] Instr = '0;
  logic         CoreRst, CoreEn, Running, Done, TraceValid;
  logic [1:0]   DoneCause;
  logic [W-1:0] CycleCnt, RetireCnt, TracePC, TraceIR;
  logic [2:0]   TraceIdx = '0;

  logic [W-1:0] exp_q[$];
  int           chk_cnt  = 0;
  int           pass_cnt = 0;

  run_monitor #(
    .ADDR_W(W), .DATA_W(W), .CNT_W(W), .MAX_CYCLES(MAXC),
    .RST_CYCLES(RSTC), .STALL_LIMIT(STALLL), .TRACE_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort), .PC(PC), .Instr(Instr),
    .CoreRst(CoreRst), .CoreEn(CoreEn), .Running(Running), .Done(Done),
    .DoneCause(DoneCause), .CycleCnt(CycleCnt), .RetireCnt(RetireCnt),
    .TraceIdx(TraceIdx), .TracePC(TracePC), .TraceIR(TraceIR), .TraceValid(TraceValid)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] sb_pop();
    if (exp_q.size() == 0) return 32'hDEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  // PC sequence presented on RUN cycle k for each pattern
  function automatic logic [W-1:0] pc_of(input int pat, input int k);
    case (pat)
      1:       return (k < 4) ? W'(4 * k) : 32'h0000_000C;
      2:       return (k < 12) ? W'(32'h100 + 4 * k) : 32'h0000_012C;
      default: return W'(4 * k);
    endcase
  endfunction

  function automatic logic [W-1:0] ir_of(input logic [W-1:0] pc);
    return pc ^ 32'hA5A5_0F0F;
  endfunction

  // Behavioural model of one run; pushes the expected results to exp_q
  task automatic push_expected(input int pat, input int abort_at);
    int           cyc = 0;
    int           ret = 0;
    int           stall = 0;
    int           cause = 0;
    logic [W-1:0] prev = '0;
    logic [W-1:0] pc;
    logic [W-1:0] tpc[$];
    for (int k = 0; k < 100000; k++) begin
      pc = pc_of(pat, k);
      cyc++;
      if (k == 0) begin
        prev = pc;
        tpc.push_back(pc);
      end else if (pc != prev) begin
        ret++;
        stall = 0;
        prev = pc;
        tpc.push_back(pc);
      end else if (stall < STALLL) begin
        stall++;
      end
      if (k == abort_at) begin cause = 3; break; end
      if (stall == STALLL) begin cause = 2; break; end
      if (cyc == MAXC) begin cause = 1; break; end
    end
    exp_q.push_back(W'(cause));
    exp_q.push_back(W'(cyc));
    exp_q.push_back(W'(ret));
    exp_q.push_back(W'(RSTC));
    for (int i = 0; i < DEPTH; i++) begin
      if (i < tpc.size()) begin
        exp_q.push_back(1);
        exp_q.push_back(tpc[tpc.size() - 1 - i]);
        exp_q.push_back(ir_of(tpc[tpc.size() - 1 - i]));
      end else begin
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    TraceIdx = '0;
    #1;
    check({tag, "_corerst"}, W'(CoreRst), 1);
    check({tag, "_coreen"}, W'(CoreEn), 0);
    check({tag, "_running"}, W'(Running), 0);
    check({tag, "_done"}, W'(Done), 0);
    check({tag, "_cause"}, W'(DoneCause), 0);
    check({tag, "_cycles"}, CycleCnt, 0);
    check({tag, "_retires"}, RetireCnt, 0);
    check({tag, "_tvalid"}, W'(TraceValid), 0);
  endtask

  // Launch a run, feed the PC pattern, then score the result at Done.
  // rst_at >= 0 instead pulses RST on that RUN cycle and checks reset values.
  task automatic do_run(input int pat, input int abort_at, input int rst_at);
    int k = 0;
    int rstc = 0;
    bit done_seen = 0;
    logic [W-1:0] ev, epc, eir;
    if (rst_at < 0) push_expected(pat, abort_at);
    @(negedge CLK);
    Start = 1'b1;
    Abort = 1'b0;
    PC    = pc_of(pat, 0);
    Instr = ir_of(PC);
    for (int c = 0; c < 5000; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      Abort = 1'b0;
      if (Done) begin done_seen = 1; break; end
      if (Running) begin
        if (k == rst_at) begin
          #2 RST = 1'b1;
          check_reset_values("async_rst");
          @(negedge CLK);
          RST = 1'b0;
          return;
        end
        PC    = pc_of(pat, k);
        Instr = ir_of(PC);
        Abort = (k == abort_at);
        if (k > 0) Start = ($urandom_range(0, 7) == 0);
        k++;
      end else if (CoreRst) begin
        rstc++;
      end
    end
    if (!done_seen) begin
      check("run_timeout", 0, 1);
      exp_q.delete();
      return;
    end
    check("done_coreen", W'(CoreEn), 0);
    check("done_corerst", W'(CoreRst), 0);
    check("cause", W'(DoneCause), sb_pop());
    check("cycles", CycleCnt, sb_pop());
    check("retires", RetireCnt, sb_pop());
    check("rst_len", W'(rstc), sb_pop());
    for (int i = 0; i < DEPTH; i++) begin
      TraceIdx = 3'(i);
      #1;
      ev  = sb_pop();
      epc = sb_pop();
      eir = sb_pop();
      check($sformatf("tvalid%0d", i), W'(TraceValid), ev);
      if (ev != 0) begin
        check($sformatf("tpc%0d", i), TracePC, epc);
        check($sformatf("tir%0d", i), TraceIR, eir);
      end
    end
  endtask

  // Main sequence and final report
  initial begin
    #12;
    check_reset_values("por");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_corerst", W'(CoreRst), 1);

    do_run(0, -1, -1);   // timeout after MAX_CYCLES
    do_run(1, -1, -1);   // halt on PC self-loop, rerun from DONE

    // Abort while DONE is ignored
    @(negedge CLK);
    Abort = 1'b1;
    @(negedge CLK);
    Abort = 1'b0;
    check("done_abort_done", W'(Done), 1);
    check("done_abort_cause", W'(DoneCause), 2);

    do_run(2, -1, -1);   // trace wrap, twelve distinct PCs
    do_run(0, 4, -1);    // abort on 5th RUN cycle
    do_run(1, 19, -1);   // abort together with halt
    do_run(0, -1, 10);   // asynchronous reset mid-run
    do_run(1, -1, -1);   // fresh run after reset

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
